spi_oversampled_peripheral: RTL

SPI peripheral front end for the camera register path. It oversamples the MCU's SPI pins (mode 0, MSB first) on the FPGA system clock and turns each transaction into the opcode/operand handshake that the camera SPI register block consumes. It also serialises that block's `response` byte back onto CIPO, and drives the read-advance pulse and the read byte counter that the register block uses to step image addresses and select multi-byte fields.

---
 rtl/spi_oversampled_peripheral.sv | 116 +++++++++++
 1 files changed

// File: rtl/spi_oversampled_peripheral.sv
// spi_oversampled_peripheral: oversampled SPI mode-0 peripheral producing opcode/operand handshakes and serialising responses on CIPO
module spi_oversampled_peripheral #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock_in,
  input  logic        reset_n_in,
  input  logic        spi_sck_in,
  input  logic        spi_cs_n_in,
  input  logic        spi_copi_in,
  output logic        spi_cipo_out,
  output logic        spi_cipo_enable_out,
  output logic [7:0]  opcode_out,
  output logic        opcode_valid_out,
  output logic [7:0]  operand_out,
  output logic        operand_valid_out,
  output logic        operand_read_out,
  output logic [31:0] rd_operand_count_out,
  input  logic [7:0]  response_in
);
  localparam logic [1:0] IDLE = 2'd0, OPCODE = 2'd1, DATA = 2'd2;
  logic [SYNC_STAGES-1:0] sck_sr, cs_sr, copi_sr;
  logic sck_prev, cs_prev;
  logic sck_s, cs_s, copi_s, rise, fall, cs_rise;
  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] rx, tx, rx_next;
  assign sck_s = sck_sr[SYNC_STAGES-1];
  assign cs_s = cs_sr[SYNC_STAGES-1];
  assign copi_s = copi_sr[SYNC_STAGES-1];
  assign rise = sck_s & ~sck_prev & ~cs_s;
  assign fall = ~sck_s & sck_prev & ~cs_s;
  assign cs_rise = cs_s & ~cs_prev;
  assign rx_next = {rx[6:0], copi_s};
  assign spi_cipo_enable_out = ~cs_s;
  // bring the asynchronous SPI pins into the clock domain and keep last sck/cs for edge detection
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      sck_sr <= '0;
      cs_sr <= '1;
      copi_sr <= '0;
      sck_prev <= 1'b0;
      cs_prev <= 1'b1;
    end else begin
      sck_sr <= {sck_sr[SYNC_STAGES-2:0], spi_sck_in};
      cs_sr <= {cs_sr[SYNC_STAGES-2:0], spi_cs_n_in};
      copi_sr <= {copi_sr[SYNC_STAGES-2:0], spi_copi_in};
      sck_prev <= sck_s;
      cs_prev <= cs_s;
    end
  end
  // transaction FSM: opcode byte, then data bytes with response shifted out; a CS rise aborts everything
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state <= IDLE;
      bit_cnt <= 3'd0;
      rx <= 8'd0;
      tx <= 8'd0;
      opcode_out <= 8'd0;
      opcode_valid_out <= 1'b0;
      operand_out <= 8'd0;
      operand_valid_out <= 1'b0;
      operand_read_out <= 1'b0;
      rd_operand_count_out <= 32'd0;
      spi_cipo_out <= 1'b0;
    end else begin
      opcode_valid_out <= 1'b0;
      operand_valid_out <= 1'b0;
      operand_read_out <= 1'b0;
      spi_cipo_out <= (state == DATA) & ~cs_s & tx[7];
      if (operand_valid_out) rd_operand_count_out <= rd_operand_count_out + 32'd1;
      if (cs_rise) begin
        state <= IDLE;
        bit_cnt <= 3'd0;
        tx <= 8'd0;
        opcode_out <= 8'd0;
        rd_operand_count_out <= 32'd0;
        spi_cipo_out <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!cs_s) begin
              bit_cnt <= 3'd0;
              rx <= 8'd0;
              tx <= 8'd0;
              state <= OPCODE;
            end
          end
          OPCODE: begin
            if (rise) begin
              rx <= rx_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                opcode_out <= rx_next;
                opcode_valid_out <= 1'b1;
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (rise) begin
              rx <= rx_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                operand_out <= rx_next;
                operand_valid_out <= 1'b1;
                operand_read_out <= 1'b1;
              end
            end
            if (fall) tx <= (bit_cnt == 3'd0) ? response_in : {tx[6:0], 1'b0};
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
